// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the memory arbiter.
//   arb_state_t  : arbiter sequencing states
//   requester_t  : which side owns the memory port
//   FUNCT3_MEM_W : word-access funct3, the idle value of mem_funct3
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } arb_state_t;

   typedef enum logic {
      CPU = 1'b0,
      DMA = 1'b1
   } requester_t;

   localparam logic [2:0] FUNCT3_MEM_W = 3'b010;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single memory port between the CPU core and a DMA
// requester, one access at a time, round-robin on ties, with a watchdog that
// aborts accesses the memory never completes.
//   clk, reset (sync, active-low)
//   cpu_*/dma_* : request payload in; rdata/busy/valid/err out per side
//   mem_*       : ce/addr/funct3/memwrite/datain out; dataout/busy/valid in
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic [31:0] cpu_addr,
   input  logic [2:0]  cpu_funct3,
   input  logic        cpu_we,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_busy,
   output logic        cpu_valid,
   output logic        cpu_err,
   input  logic        dma_req,
   input  logic [31:0] dma_addr,
   input  logic [2:0]  dma_funct3,
   input  logic        dma_we,
   input  logic [31:0] dma_wdata,
   output logic [31:0] dma_rdata,
   output logic        dma_busy,
   output logic        dma_valid,
   output logic        dma_err,
   output logic        mem_ce,
   output logic [31:0] mem_addr,
   output logic [2:0]  mem_funct3,
   output logic        mem_memwrite,
   output logic [31:0] mem_datain,
   input  logic [31:0] mem_dataout,
   input  logic        mem_busy,
   input  logic        mem_valid
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   arb_state_t       r_state, w_state_nxt;
   requester_t       r_grant, w_grant_nxt;
   requester_t       r_last_grant, w_last_nxt;
   logic [CNT_W-1:0] r_cnt;

   logic w_active, w_timeout, w_done, w_err, w_gcpu;

   assign w_active  = (r_state != IDLE);
   assign w_gcpu    = (r_grant == CPU);
   // Counter reads 0 in the first WAIT cycle, so the N-th WAIT cycle is N-1.
   assign w_timeout = (r_state == WAIT) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   // Gated by reset so an access killed by reset never produces a pulse.
   assign w_done    = reset && (r_state == WAIT) && (mem_valid || w_timeout);
   // mem_valid wins over a coincident timeout.
   assign w_err     = w_done && !mem_valid;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_grant      <= CPU;
         r_last_grant <= DMA;
         r_cnt        <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_grant      <= w_grant_nxt;
         r_last_grant <= w_last_nxt;
         // Clearing throughout ISSUE gives a zero count on WAIT entry.
         if (r_state == ISSUE)
            r_cnt <= '0;
         else if (r_state == WAIT)
            r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_last_nxt  = r_last_grant;
      mem_ce      = 1'b0;
      case (r_state)
         IDLE: begin
            if (cpu_req && dma_req) begin
               w_grant_nxt = (r_last_grant == CPU) ? DMA : CPU;
               w_state_nxt = ISSUE;
            end else if (cpu_req) begin
               w_grant_nxt = CPU;
               w_state_nxt = ISSUE;
            end else if (dma_req) begin
               w_grant_nxt = DMA;
               w_state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            mem_ce = !mem_busy;
            if (!mem_busy)
               w_state_nxt = WAIT;
         end
         WAIT: begin
            if (w_done) begin
               w_last_nxt  = r_grant;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Payload follows the grant in ISSUE/WAIT; idle value is a zeroed word access.
   assign mem_addr     = !w_active ? 32'd0        : (w_gcpu ? cpu_addr   : dma_addr);
   assign mem_funct3   = !w_active ? FUNCT3_MEM_W : (w_gcpu ? cpu_funct3 : dma_funct3);
   assign mem_memwrite = !w_active ? 1'b0         : (w_gcpu ? cpu_we     : dma_we);
   assign mem_datain   = !w_active ? 32'd0        : (w_gcpu ? cpu_wdata  : dma_wdata);

   assign cpu_valid = w_done &&  w_gcpu;
   assign dma_valid = w_done && !w_gcpu;
   assign cpu_err   = w_err  &&  w_gcpu;
   assign dma_err   = w_err  && !w_gcpu;

   // Aborted accesses return zero rather than whatever the bus happens to hold.
   assign cpu_rdata = (w_active &&  w_gcpu && !w_err) ? mem_dataout : 32'd0;
   assign dma_rdata = (w_active && !w_gcpu && !w_err) ? mem_dataout : 32'd0;

   assign cpu_busy = cpu_req && !cpu_valid;
   assign dma_busy = dma_req && !dma_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (TIMEOUT_CYCLES = 8).
// Inputs change 2 time units after each rising edge; outputs are sampled 1
// unit later, well clear of the next edge.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, dma_req;
   logic [31:0] cpu_addr, dma_addr, cpu_wdata, dma_wdata;
   logic [2:0]  cpu_funct3, dma_funct3;
   logic        cpu_we, dma_we;
   logic [31:0] cpu_rdata, dma_rdata;
   logic        cpu_busy, dma_busy, cpu_valid, dma_valid, cpu_err, dma_err;
   logic        mem_ce, mem_memwrite, mem_busy, mem_valid;
   logic [31:0] mem_addr, mem_datain, mem_dataout;
   logic [2:0]  mem_funct3;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_funct3(cpu_funct3),
      .cpu_we(cpu_we), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
      .cpu_busy(cpu_busy), .cpu_valid(cpu_valid), .cpu_err(cpu_err),
      .dma_req(dma_req), .dma_addr(dma_addr), .dma_funct3(dma_funct3),
      .dma_we(dma_we), .dma_wdata(dma_wdata), .dma_rdata(dma_rdata),
      .dma_busy(dma_busy), .dma_valid(dma_valid), .dma_err(dma_err),
      .mem_ce(mem_ce), .mem_addr(mem_addr), .mem_funct3(mem_funct3),
      .mem_memwrite(mem_memwrite), .mem_datain(mem_datain),
      .mem_dataout(mem_dataout), .mem_busy(mem_busy), .mem_valid(mem_valid)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance into the next cycle; caller then drives inputs and checks.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_check(input string tag);
      chk({tag, ".ce"},     {31'd0, mem_ce},       32'd0);
      chk({tag, ".addr"},   mem_addr,              32'd0);
      chk({tag, ".f3"},     {29'd0, mem_funct3},   32'd2);
      chk({tag, ".we"},     {31'd0, mem_memwrite}, 32'd0);
      chk({tag, ".din"},    mem_datain,            32'd0);
   endtask

   initial begin
      reset = 1'b0; cpu_req = 0; dma_req = 0;
      cpu_addr = 0; dma_addr = 0; cpu_wdata = 0; dma_wdata = 0;
      cpu_funct3 = 3'b010; dma_funct3 = 3'b010; cpu_we = 0; dma_we = 0;
      mem_busy = 0; mem_valid = 0; mem_dataout = 32'hFFFF_FFFF;

      // ---- reset state ----
      tick(); tick(); settle();
      idle_check("rst");
      chk("rst.valid", {30'd0, cpu_valid, dma_valid}, 32'd0);
      chk("rst.err",   {30'd0, cpu_err, dma_err},     32'd0);
      chk("rst.busy",  {30'd0, cpu_busy, dma_busy},   32'd0);
      chk("rst.crd",   cpu_rdata, 32'd0);
      chk("rst.drd",   dma_rdata, 32'd0);

      // ---- CPU only LW 0x100, memory completes at cycle 5 ----
      tick(); reset = 1'b1; mem_dataout = 0;
      cpu_req = 1; cpu_addr = 32'h100; cpu_funct3 = 3'b010; settle();
      chk("c0.ce", {31'd0, mem_ce}, 32'd0);
      chk("c0.busy", {31'd0, cpu_busy}, 32'd1);
      tick(); settle();
      chk("c1.ce", {31'd0, mem_ce}, 32'd1);
      chk("c1.addr", mem_addr, 32'h100);
      tick(); settle();
      chk("c2.ce", {31'd0, mem_ce}, 32'd0);
      tick(); tick(); settle();
      chk("c4.valid", {31'd0, cpu_valid}, 32'd0);
      tick(); mem_valid = 1; mem_dataout = 32'hDEADBEEF; settle();
      chk("c5.cvalid", {31'd0, cpu_valid}, 32'd1);
      chk("c5.rdata", cpu_rdata, 32'hDEADBEEF);
      chk("c5.dvalid", {31'd0, dma_valid}, 32'd0);
      chk("c5.busy", {31'd0, cpu_busy}, 32'd0);
      chk("c5.err", {31'd0, cpu_err}, 32'd0);
      tick(); mem_valid = 0; cpu_req = 0; settle();
      chk("c6.valid", {31'd0, cpu_valid}, 32'd0);
      idle_check("c6");

      // ---- both held after reset: CPU, DMA, CPU, DMA ----
      tick(); reset = 1'b0;
      tick(); reset = 1'b1;
      cpu_req = 1; cpu_addr = 32'h200; dma_req = 1; dma_addr = 32'h300;
      for (int k = 0; k < 4; k++) begin
         logic exp_dma;
         exp_dma = k[0];
         if (k != 0) tick();
         mem_valid = 0; settle();                 // IDLE
         tick(); settle();                        // ISSUE
         chk($sformatf("rr%0d.ce", k), {31'd0, mem_ce}, 32'd1);
         chk($sformatf("rr%0d.addr", k), mem_addr, exp_dma ? 32'h300 : 32'h200);
         tick(); settle();                        // WAIT
         tick(); mem_valid = 1; mem_dataout = 32'hA0 + k; settle();
         chk($sformatf("rr%0d.cv", k), {31'd0, cpu_valid}, {31'd0, !exp_dma});
         chk($sformatf("rr%0d.dv", k), {31'd0, dma_valid}, {31'd0, exp_dma});
         chk($sformatf("rr%0d.lbusy", k), {31'd0, exp_dma ? cpu_busy : dma_busy}, 32'd1);
         chk($sformatf("rr%0d.rd", k), exp_dma ? dma_rdata : cpu_rdata, 32'hA0 + k);
      end
      tick(); mem_valid = 0; cpu_req = 0; dma_req = 0; settle();
      idle_check("rr.end");

      // ---- DMA SW with mem_busy high for 3 ISSUE cycles ----
      tick(); dma_req = 1; dma_we = 1; dma_wdata = 32'h12345678;
      dma_addr = 32'h400; mem_busy = 1; settle();
      chk("sw.busy", {31'd0, dma_busy}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick(); settle();
         chk($sformatf("sw.hold%0d.ce", i), {31'd0, mem_ce}, 32'd0);
         chk($sformatf("sw.hold%0d.we", i), {31'd0, mem_memwrite}, 32'd1);
      end
      tick(); mem_busy = 0; settle();
      chk("sw.ce", {31'd0, mem_ce}, 32'd1);
      chk("sw.din", mem_datain, 32'h12345678);
      tick(); settle();
      chk("sw.wait.ce", {31'd0, mem_ce}, 32'd0);
      chk("sw.wait.we", {31'd0, mem_memwrite}, 32'd1);
      tick(); mem_valid = 1; settle();
      chk("sw.dv", {31'd0, dma_valid}, 32'd1);
      chk("sw.cv", {31'd0, cpu_valid}, 32'd0);
      chk("sw.fin.din", mem_datain, 32'h12345678);
      chk("sw.fin.we", {31'd0, mem_memwrite}, 32'd1);
      tick(); mem_valid = 0; dma_req = 0; dma_we = 0; settle();
      idle_check("sw.end");

      // ---- timeout after 8 WAIT cycles, no mem_valid ----
      tick(); cpu_req = 1; cpu_addr = 32'h500; cpu_funct3 = 3'b000; settle();
      tick(); settle();
      chk("to.ce", {31'd0, mem_ce}, 32'd1);
      for (int i = 0; i < 8; i++) begin
         tick(); mem_dataout = 32'hAAAA5555; settle();
         chk($sformatf("to.w%0d.f3", i), {29'd0, mem_funct3}, 32'd0);
         if (i < 7) begin
            chk($sformatf("to.w%0d.cv", i), {31'd0, cpu_valid}, 32'd0);
         end else begin
            chk("to.cv", {31'd0, cpu_valid}, 32'd1);
            chk("to.err", {31'd0, cpu_err}, 32'd1);
            chk("to.rd", cpu_rdata, 32'd0);
            chk("to.dv", {31'd0, dma_valid}, 32'd0);
         end
      end
      tick(); cpu_req = 0; settle();
      chk("to.after.cv", {31'd0, cpu_valid}, 32'd0);
      idle_check("to.after");

      // ---- mem_valid on the final timeout cycle: data wins ----
      tick(); cpu_req = 1; cpu_addr = 32'h600; settle();
      tick(); settle();
      for (int i = 0; i < 8; i++) begin
         tick();
         if (i == 7) begin
            mem_valid = 1; mem_dataout = 32'hCAFEF00D;
         end
         settle();
      end
      chk("tv.cv", {31'd0, cpu_valid}, 32'd1);
      chk("tv.err", {31'd0, cpu_err}, 32'd0);
      chk("tv.rd", cpu_rdata, 32'hCAFEF00D);
      tick(); mem_valid = 0; cpu_req = 0; cpu_funct3 = 3'b010; settle();
      idle_check("tv.after");

      // ---- spurious mem_valid in IDLE ----
      tick(); mem_valid = 1; settle();
      chk("sp.valid", {30'd0, cpu_valid, dma_valid}, 32'd0);

      // ---- reset during WAIT of a DMA access ----
      tick(); mem_valid = 0; dma_req = 1; dma_addr = 32'h700;
      dma_we = 1; dma_wdata = 32'h55; settle();
      tick(); settle();
      chk("rw.ce", {31'd0, mem_ce}, 32'd1);
      tick(); settle();
      tick(); reset = 1'b0; settle();
      chk("rw.rst.dv", {31'd0, dma_valid}, 32'd0);
      tick(); reset = 1'b1; dma_req = 0; dma_we = 0; mem_valid = 1; settle();
      chk("rw.dv", {31'd0, dma_valid}, 32'd0);
      chk("rw.drd", dma_rdata, 32'd0);
      idle_check("rw");
      tick(); mem_valid = 0; settle();
      chk("rw.next.ce", {31'd0, mem_ce}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single `memory` port (SPI SRAM, UART, I2C, GPIO, radio registers) between the CPU core and a DMA requester, such as a radio sample mover.
- It sits between `cpu` and `memory` and owns the memory-side `ce`/`addr`/`funct3`/`memwrite`/`datain` signals.
- It sequences exactly one access at a time, using round-robin arbitration when both sides request.
- A watchdog aborts any access the memory never completes.

## Interface
- `TIMEOUT_CYCLES`, default 4096: maximum cycles in WAIT before the access is aborted with an error.
- `clk  input  1  clock`
- `reset  input  1  reset, synchronous, active-low`
- `cpu_req, dma_req  input  1  access request`
  - Level signal; held with stable payload until the matching `*_valid`.
  - Dropped in the cycle after `*_valid`.
- `cpu_addr, dma_addr  input  32  byte address`
- `cpu_funct3, dma_funct3  input  3  access size/sign, memory funct3 encoding`
- `cpu_we, dma_we  input  1  1 = store`
- `cpu_wdata, dma_wdata  input  32  store data`
- `cpu_rdata, dma_rdata  output  32  load data; equals `mem_dataout` while granted, 0 otherwise`
- `cpu_busy, dma_busy  output  1  request pending and not yet completed`
- `cpu_valid, dma_valid  output  1  one-cycle completion pulse`
- `cpu_err, dma_err  output  1  one-cycle pulse coincident with `*_valid` on timeout abort`
- `mem_ce  output  1  start-of-access strobe to memory`
- `mem_addr  output  32  address to memory`
- `mem_funct3  output  3  funct3 to memory`
- `mem_memwrite  output  1  write enable to memory`
- `mem_datain  output  32  store data to memory`
- `mem_dataout  input  32  load data from memory`
- `mem_busy  input  1  memory access in progress`
- `mem_valid  input  1  memory completion pulse`

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If exactly one `*_req` is high, register `grant` to that requester and go to ISSUE.
  - If both are high, grant the requester not named by `last_grant`.
  - If neither is high, stay in IDLE.
- ISSUE:
  - `mem_ce = !mem_busy`.
  - Once `mem_ce` has been asserted (`mem_busy` low), go to WAIT.
  - Otherwise stay in ISSUE with `mem_ce` low.
- WAIT:
  - `mem_ce = 0`.
  - On `mem_valid`, pulse the granted requester's `*_valid` combinationally in the same cycle, update `last_grant <= grant`, and go to IDLE.
- Memory payload (`mem_addr`, `mem_funct3`, `mem_memwrite`, `mem_datain`):
  - Muxed from the granted requester in ISSUE and WAIT.
  - In IDLE: all zero, with `mem_funct3 = FUNCT3_MEM_W`.
- Busy:
  - `*_busy = *_req && !*_valid`.
  - The losing requester stays busy throughout the other side's access.
- Watchdog:
  - A 13-bit or wider counter (`$clog2(TIMEOUT_CYCLES+1)` bits) clears on entry to WAIT and increments each WAIT cycle.
  - At `TIMEOUT_CYCLES` without `mem_valid`: pulse `*_valid` and `*_err` to the granted requester, drive `*_rdata = 0`, update `last_grant`, go to IDLE.
- `mem_valid` and timeout in the same cycle: `mem_valid` wins, `*_err = 0`.
- `mem_valid` while in IDLE or ISSUE (spurious): ignored, no requester pulse.
- A request dropped before completion is a protocol violation. The arbiter still finishes the access and pulses `*_valid`.

## Timing
- Reset values:
  - State IDLE, `grant = CPU`, `last_grant = DMA` (CPU wins the first tie), counter 0.
  - All `mem_*` outputs 0 except `mem_funct3 = FUNCT3_MEM_W`.
  - All `*_valid`, `*_err`, `*_busy` 0.
  - `*_rdata` 0.
- Reset mid-access: returns to IDLE next edge and no pulse is generated. Memory is reset by the same signal.
- Latency: request at cycle 0 (IDLE), `mem_ce` at cycle 1, `*_valid` in the same cycle as `mem_valid`. Back-to-back accesses cost 2 arbiter cycles of overhead.
- `mem_ce` is high for exactly one cycle per access.
- Payload is stable from ISSUE until the completion cycle inclusive.

## Structure
- `arb_state_t` (IDLE/ISSUE/WAIT) and the `requester_t` enum (CPU/DMA) go in the shared constants package, next to `FUNCT3_MEM_W`.
- The arbiter is a single module; no sub-module is needed.
- Integration: `cpu` instantiates `mem_arbiter` between its fetch/load-store mux and `memory`.

## Test plan
- CPU only: `cpu_req` LW at `0x100`.
  - Expect `mem_ce` at cycle 1 with `mem_addr = 0x100`.
  - Memory returns `0xDEADBEEF` with `mem_valid` at cycle 5.
  - Expect `cpu_valid = 1` and `cpu_rdata = 0xDEADBEEF` at cycle 5; `dma_valid` stays 0.
- Simultaneous requests after reset:
  - CPU is served first, then DMA.
  - With both held continuously, grants alternate CPU, DMA, CPU, DMA over 4 accesses.
- DMA SW (`dma_we = 1`, `wdata = 0x12345678`) while `mem_busy = 1` for 3 cycles in ISSUE:
  - `mem_ce` stays low until `mem_busy` falls, then pulses once.
  - `mem_memwrite = 1` and `mem_datain = 0x12345678` are held until `mem_valid`.
- Timeout with `TIMEOUT_CYCLES = 8` and `mem_valid` never asserted:
  - Expect `cpu_valid = cpu_err = 1` and `cpu_rdata = 0` after exactly 8 WAIT cycles, then the state returns to IDLE.
- `mem_valid` coincides with the final timeout cycle: `cpu_valid = 1`, `cpu_err = 0`, data passed through.
- Reset asserted during WAIT of a DMA access: next cycle state is IDLE, no `dma_valid`, and `mem_*` outputs are at reset values.
